// File: rtl/prewish_pkg.sv
// Shared widths and default parameters for the prewish LED pattern system.
package prewish_pkg;
  localparam int DATA_W               = 8;
  localparam int IDX_W                = $clog2(DATA_W);
  localparam int DEF_POR_CYCLES       = 4;
  localparam int DEF_SYSCLK_DIV_BITS  = 22;
endpackage

// File: rtl/prewish_if.sv
// Strobe/data bus carrying one pattern byte from the mentor to blinky.
interface prewish_if;
  import prewish_pkg::*;
  logic              stb;
  logic [DATA_W-1:0] dat;
  modport master (output stb, output dat);
  modport slave  (input  stb, input  dat);
endinterface

// File: rtl/prewish_blinky.sv
// Slave that plays the loaded byte on one LED, MSB first, one bit per
// prescaler period, looping until reloaded or reset.
module prewish_blinky
  import prewish_pkg::*;
#(
  parameter int SYSCLK_DIV_BITS = DEF_SYSCLK_DIV_BITS
) (
  input  logic      clk,
  input  logic      rst,
  prewish_if.slave  wb,
  output logic      led_o
);
  logic [DATA_W-1:0]          mask_q, mask_d;
  logic [SYSCLK_DIV_BITS-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       led_q;

  // A load restarts the bit period so the new MSB gets its full duration.
  always_comb begin
    mask_d  = mask_q;
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (wb.stb) begin
      mask_d  = wb.dat;
      presc_d = '0;
      idx_d   = IDX_W'(DATA_W - 1);
    end else if (&presc_q) begin
      idx_d = idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q  <= '0;
      presc_q <= '0;
      idx_q   <= IDX_W'(DATA_W - 1);
      led_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      led_q   <= mask_q[idx_q];
    end
  end

  assign led_o = led_q;
endmodule

// File: rtl/prewish_mentor.sv
// Stimulus master: turns each rising edge of a level strobe into a one-clock
// bus strobe carrying the byte present at that edge.
module prewish_mentor
  import prewish_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stb_i,
  input  logic [DATA_W-1:0] dat_i,
  prewish_if.master         wb
);
  logic              stb_in_q;
  logic              stb_o_q, stb_o_d;
  logic [DATA_W-1:0] dat_o_q, dat_o_d;

  always_comb begin
    stb_o_d = 1'b0;
    dat_o_d = dat_o_q;
    if (stb_i && !stb_in_q) begin
      stb_o_d = 1'b1;
      dat_o_d = dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_in_q <= 1'b0;
      stb_o_q  <= 1'b0;
      dat_o_q  <= '0;
    end else begin
      stb_in_q <= stb_i;
      stb_o_q  <= stb_o_d;
      dat_o_q  <= dat_o_d;
    end
  end

  assign wb.stb = stb_o_q;
  assign wb.dat = dat_o_q;
endmodule

// File: rtl/prewish_syscon.sv
// Clock/reset source: buffered clock and a reset stretched for POR_CYCLES clocks
// after power-up or after the external reset releases.
module prewish_syscon #(
  parameter int POR_CYCLES = prewish_pkg::DEF_POR_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic clk_o,
  output logic rst_o
);
  localparam int CNT_W = $clog2(POR_CYCLES + 1);

  // Power-up value comes from the FPGA configuration, so no external reset is needed.
  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] cnt_d;
  logic             por_act;

  SB_GB u_gb (
    .USER_SIGNAL_TO_GLOBAL_BUFFER (clk_i),
    .GLOBAL_BUFFER_OUTPUT         (clk_o)
  );

  assign por_act = (cnt_q != CNT_W'(POR_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (por_act) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_o or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign rst_o = rst_i | por_act;
endmodule

// File: rtl/sb_gb.sv
// Simulation passthrough model of the iCE40 global clock buffer.
module SB_GB (
  input  logic USER_SIGNAL_TO_GLOBAL_BUFFER,
  output logic GLOBAL_BUFFER_OUTPUT
);
  assign GLOBAL_BUFFER_OUTPUT = USER_SIGNAL_TO_GLOBAL_BUFFER;
endmodule

// File: rtl/prewish_blinky_sys.sv
// Board-level LED pattern system: syscon, mentor and blinky wired together.
module prewish_blinky_sys
  import prewish_pkg::*;
#(
  parameter int SYSCLK_DIV_BITS = DEF_SYSCLK_DIV_BITS,
  parameter int POR_CYCLES      = DEF_POR_CYCLES
) (
  input  logic              i_clk,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [DATA_W-1:0] DAT_I,
  output logic              o_led
);
  logic clk_w;
  logic rst_w;

  prewish_if bus ();

  prewish_syscon #(.POR_CYCLES(POR_CYCLES)) u_syscon (
    .clk_i (i_clk),
    .rst_i (RST_I),
    .clk_o (clk_w),
    .rst_o (rst_w)
  );

  prewish_mentor u_mentor (
    .clk   (clk_w),
    .rst   (rst_w),
    .stb_i (STB_I),
    .dat_i (DAT_I),
    .wb    (bus.master)
  );

  prewish_blinky #(.SYSCLK_DIV_BITS(SYSCLK_DIV_BITS)) u_blinky (
    .clk   (clk_w),
    .rst   (rst_w),
    .wb    (bus.slave),
    .led_o (o_led)
  );
endmodule

// File: tb/tb_prewish_blinky_sys.sv
// Scoreboard bench: a cycle model derived from the pattern timing rules queues the
// expected LED and reset each clock; a negedge monitor pops and compares.
module tb_prewish_blinky_sys;
  import prewish_pkg::*;

  localparam int DIV      = 3;
  localparam int BIT_CLKS = 1 << DIV;
  localparam int POR      = 4;

  typedef struct packed { logic led; logic rst; } exp_t;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic o_led;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_cyc = 0;
  exp_t exp_q[$];

  prewish_if stim ();

  prewish_blinky_sys #(.SYSCLK_DIV_BITS(DIV), .POR_CYCLES(POR)) dut (
    .i_clk (clk),
    .RST_I (rst_i),
    .STB_I (stim.stb),
    .DAT_I (stim.dat),
    .o_led (o_led)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic act, input logic req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, req, n_cyc);
  endfunction

  // Reference model: pattern = (mask, load cycle L); LED after edge n shows
  // mask[7 - ((n-L-1)/BIT_CLKS mod 8)], a new load takes effect one edge after the strobe edge.
  int                por_cnt = 0;
  logic              prev_stb = 1'b0;
  logic              pend = 1'b0;
  logic [DATA_W-1:0] pend_dat = '0;
  logic [DATA_W-1:0] m_mask = '0;
  int                m_load = 0;

  always @(posedge clk) begin : model
    exp_t e;
    int   slot;
    bit   in_rst;
    n_cyc++;
    in_rst = rst_i || (por_cnt < POR);
    e.led = 1'b0;
    if (in_rst) begin
      m_mask   = '0;
      m_load   = n_cyc;
      pend     = 1'b0;
      prev_stb = 1'b0;
    end else begin
      if (n_cyc > m_load) begin
        slot  = ((n_cyc - m_load - 1) / BIT_CLKS) % DATA_W;
        e.led = m_mask[DATA_W-1-slot];
      end
      if (pend) begin
        m_mask = pend_dat;
        m_load = n_cyc;
      end
      pend = stim.stb && !prev_stb;
      if (pend) pend_dat = stim.dat;
      prev_stb = stim.stb;
    end
    if (rst_i) por_cnt = 0;
    else if (por_cnt < POR) por_cnt++;
    e.rst = rst_i || (por_cnt < POR);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("led", o_led, e.led);
      check("rst_o", dut.rst_w, e.rst);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic strobe(input logic [DATA_W-1:0] d, input int hold, input bit scramble);
    stim.dat = d;
    stim.stb = 1'b1;
    repeat (hold) begin
      @(negedge clk); #1;
      if (scramble) stim.dat = DATA_W'($urandom);
    end
    stim.stb = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_i = 1'b1;
    #1;
    check("async_led", o_led, 1'b0);
    check("async_rst", dut.rst_w, 1'b1);
    idle(2);
    rst_i = 1'b0;
  endtask

  initial begin
    stim.stb = 1'b0;
    stim.dat = '0;
    // power-up with no stimulus
    idle(12);
    // 0x54 held ~10 clocks, one pulse, pattern plays twice
    strobe(8'h54, 10, 1'b0);
    idle(140);
    // 0xCA held ~350 clocks with changing data
    strobe(8'hCA, 350, 1'b1);
    idle(20);
    // reload mid-bit
    strobe(8'h54, 1, 1'b0);
    idle(12);
    strobe(8'hCA, 2, 1'b0);
    idle(70);
    // reset mid-pattern, LED stays dark
    reset_pulse();
    idle(40);
    // all-ones then all-zeros
    strobe(8'hFF, 1, 1'b0);
    idle(70);
    strobe(8'h00, 1, 1'b0);
    idle(30);
    // randomized loads, holds, gaps and occasional resets
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        reset_pulse();
        idle($urandom_range(1, 8));
      end
      strobe(DATA_W'($urandom), $urandom_range(1, 12), 1'b1);
      idle($urandom_range(1, 60));
    end
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
